// File: rtl/bu2020_mem_pkg.sv
// Shared definitions for the BU2020 unified memory and the core that talks to it.
package bu2020_mem_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;
    localparam logic [DATA_W-1:0] NOP_WORD = 16'hD000;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] word_t;

    typedef enum logic {
        INIT,
        READY
    } mem_state_t;

endpackage

// File: rtl/bu2020_memory_if.sv
// Bus bundle between the BU2020 core (master) and its unified memory (slave).
// Signal names mirror the core's own bus names.
interface bu2020_memory_if #(
    parameter int ADDR_W = bu2020_mem_pkg::ADDR_W,
    parameter int DATA_W = bu2020_mem_pkg::DATA_W
);

    logic [ADDR_W-1:0] Memory_addressbus;
    logic [DATA_W-1:0] Memory_databus;
    logic [DATA_W-1:0] Memory_incoming_data_bus;
    logic              Memory_writemode;
    logic [ADDR_W-1:0] Instruction_addressbus;
    logic [DATA_W-1:0] Instruction_databus;
    logic              mem_ready;
    logic              addr_err;
    logic              prot_err;

    modport master (
        output Memory_addressbus,
        output Memory_incoming_data_bus,
        output Memory_writemode,
        output Instruction_addressbus,
        input  Memory_databus,
        input  Instruction_databus,
        input  mem_ready,
        input  addr_err,
        input  prot_err
    );

    modport slave (
        input  Memory_addressbus,
        input  Memory_incoming_data_bus,
        input  Memory_writemode,
        input  Instruction_addressbus,
        output Memory_databus,
        output Instruction_databus,
        output mem_ready,
        output addr_err,
        output prot_err
    );

endinterface

// File: rtl/bu2020_mem_clear_seq.sv
// Post-reset clear sequencer: walks every word once writing zero, then
// declares the memory ready. Reset at any time restarts the walk at word 0.
module bu2020_mem_clear_seq #(
    parameter int DEPTH = 4096,
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    output logic             clr_we,
    output logic [CNT_W-1:0] clr_addr,
    output logic             ready
);
    import bu2020_mem_pkg::*;

    localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(DEPTH - 1);

    mem_state_t       state_q;
    logic [CNT_W-1:0] clr_cnt_q;
    logic             clr_we_q;
    logic             ready_q;

    // Clear FSM: one zero-write per cycle in INIT, READY after the last word is written.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= INIT;
            clr_cnt_q <= '0;
            clr_we_q  <= 1'b1;
            ready_q   <= 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    if (clr_cnt_q == LAST_ADDR) begin
                        state_q  <= READY;
                        clr_we_q <= 1'b0;
                        ready_q  <= 1'b1;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + 1'b1;
                    end
                end
                READY: begin
                    clr_we_q <= 1'b0;
                    ready_q  <= 1'b1;
                end
                default: begin
                    state_q   <= INIT;
                    clr_cnt_q <= '0;
                    clr_we_q  <= 1'b1;
                    ready_q   <= 1'b0;
                end
            endcase
        end
    end

    assign clr_we   = clr_we_q;
    assign clr_addr = clr_cnt_q;
    assign ready    = ready_q;

endmodule

// File: rtl/bu2020_memory.sv
// BU2020 unified word-addressed memory: asynchronous-read instruction and data
// ports, synchronous writes on the data port, zero-fill after every reset.
// Optional write protection of the low region is enabled by defining
// BU2020_MEM_WRITE_PROTECT_EN (addresses below PROTECT_LIMIT become read-only).
module bu2020_memory #(
    parameter int                DEPTH         = 4096,
    parameter int                ADDR_W        = bu2020_mem_pkg::ADDR_W,
    parameter int                DATA_W        = bu2020_mem_pkg::DATA_W,
    parameter logic [DATA_W-1:0] NOP_WORD      = bu2020_mem_pkg::NOP_WORD,
    parameter int                PROTECT_LIMIT = 256
) (
    input logic             clk,
    input logic             rst,
    bu2020_memory_if.slave  bus
);
    import bu2020_mem_pkg::*;

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic             clrWe;
    logic [IDX_W-1:0] clrAddr;
    logic             ready;
    logic             dataInRange;
    logic             instrInRange;
    logic [IDX_W-1:0] dataIdx;
    logic [IDX_W-1:0] instrIdx;
    logic             protHit;
    logic             userWrite;
    logic             addrErr_q;
    logic             addrErr_d;

    bu2020_mem_clear_seq #(
        .DEPTH (DEPTH),
        .CNT_W (IDX_W)
    ) clearSeq (
        .clk      (clk),
        .rst      (rst),
        .clr_we   (clrWe),
        .clr_addr (clrAddr),
        .ready    (ready)
    );

    // Addresses are unsigned with no wrap; the extra top bit keeps DEPTH == 2^ADDR_W legal.
    assign dataInRange  = ({1'b0, bus.Memory_addressbus} < DEPTH_EXT);
    assign instrInRange = ({1'b0, bus.Instruction_addressbus} < DEPTH_EXT);
    assign dataIdx      = bus.Memory_addressbus[IDX_W-1:0];
    assign instrIdx     = bus.Instruction_addressbus[IDX_W-1:0];

`ifdef BU2020_MEM_WRITE_PROTECT_EN
    localparam logic [ADDR_W:0] LIMIT_EXT = (ADDR_W + 1)'(PROTECT_LIMIT);
    logic protErr_q;
    logic protErr_d;

    assign protHit = ({1'b0, bus.Memory_addressbus} < LIMIT_EXT);

    // Blocked-write flag is sticky until reset and only armed once the clear has finished.
    always_comb begin
        protErr_d = protErr_q;
        if (ready && bus.Memory_writemode && dataInRange && protHit) begin
            protErr_d = 1'b1;
        end
    end

    // Register the protection flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            protErr_q <= 1'b0;
        end else begin
            protErr_q <= protErr_d;
        end
    end

    assign bus.prot_err = protErr_q;
`else
    assign protHit      = 1'b0;
    assign bus.prot_err = 1'b0;
`endif

    assign userWrite = ready && !rst && bus.Memory_writemode && dataInRange && !protHit;

    // Array write port: the clear sequencer owns it in INIT, the data port afterwards.
    always_ff @(posedge clk) begin
        if (clrWe) begin
            mem[clrAddr] <= '0;
        end else if (userWrite) begin
            mem[dataIdx] <= bus.Memory_incoming_data_bus;
        end
    end

    // Data read port: zero while clearing or when the address is outside the array.
    always_comb begin
        bus.Memory_databus = '0;
        if (ready && dataInRange) begin
            bus.Memory_databus = mem[dataIdx];
        end
    end

    // Fetch port: feed the core a NOP until memory is ready or when fetching outside the array.
    always_comb begin
        bus.Instruction_databus = NOP_WORD;
        if (ready && instrInRange) begin
            bus.Instruction_databus = mem[instrIdx];
        end
    end

    // Any out-of-range access on either port after the clear latches the address error.
    always_comb begin
        addrErr_d = addrErr_q;
        if (ready && (!dataInRange || !instrInRange)) begin
            addrErr_d = 1'b1;
        end
    end

    // Register the address error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            addrErr_q <= 1'b0;
        end else begin
            addrErr_q <= addrErr_d;
        end
    end

    assign bus.addr_err  = addrErr_q;
    assign bus.mem_ready = ready;

endmodule

// File: tb/tb_bu2020_memory.sv
// Directed testbench for bu2020_memory: a 16-word instance exercises timing,
// range and protection behaviour; a full-size instance covers the 0x123 write.
module tb_bu2020_memory;
    import bu2020_mem_pkg::*;

    localparam int SMALL_DEPTH = 16;
    localparam int SMALL_LIMIT = 4;
    localparam int INIT_BOUND  = 40;
    localparam int BIG_BOUND   = 5000;

    typedef struct {
        string       tag;
        logic [31:0] value;
    } expect_t;

    logic    clk = 1'b0;
    logic    rst = 1'b0;
    int      assertCount = 0;
    int      failCount = 0;
    expect_t sbQueue[$];

    always #5 clk = ~clk;

    bu2020_memory_if smallBus ();
    bu2020_memory_if bigBus ();

    bu2020_memory #(
        .DEPTH         (SMALL_DEPTH),
        .ADDR_W        (ADDR_W),
        .DATA_W        (DATA_W),
        .NOP_WORD      (NOP_WORD),
        .PROTECT_LIMIT (SMALL_LIMIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (smallBus.slave)
    );

    bu2020_memory bigDut (
        .clk (clk),
        .rst (rst),
        .bus (bigBus.slave)
    );

    task automatic pushExpect(input string tag, input logic [31:0] value);
        expect_t e;
        e.tag   = tag;
        e.value = value;
        sbQueue.push_back(e);
    endtask

    task automatic checkOutput(input logic [31:0] observed);
        expect_t e;
        assertCount++;
        if (sbQueue.size() == 0) begin
            failCount++;
            $error("[TB] FAIL scoreboard_empty observed=%h expected=none", observed);
        end else begin
            e = sbQueue.pop_front();
            assert (observed === e.value) else begin
                failCount++;
                $error("[TB] FAIL %s observed=%h expected=%h", e.tag, observed, e.value);
            end
        end
    endtask

    task automatic checkWord(input logic [15:0] observed);
        checkOutput({16'h0000, observed});
    endtask

    task automatic checkBit(input logic observed);
        checkOutput({31'h0, observed});
    endtask

    task automatic applyStimulus(input logic [11:0] addr, input logic [15:0] wdata,
                                 input logic we, input logic [11:0] iaddr);
        smallBus.Memory_addressbus        = addr;
        smallBus.Memory_incoming_data_bus = wdata;
        smallBus.Memory_writemode         = we;
        smallBus.Instruction_addressbus   = iaddr;
        #1;
    endtask

    // Called at a falling edge; holds reset for the given number of rising edges.
    task automatic resetDut(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(negedge clk);
        #1;
        pushExpect("rst_mem_ready", 32'd0);
        checkBit(smallBus.mem_ready);
        pushExpect("rst_addr_err", 32'd0);
        checkBit(smallBus.addr_err);
        pushExpect("rst_prot_err", 32'd0);
        checkBit(smallBus.prot_err);
        rst = 1'b0;
    endtask

    // Counts cycles with mem_ready low after release; stops driving writes after writeCycles.
    task automatic waitSmallReady(input int writeCycles, output int cycles);
        cycles = 0;
        #1;
        while (smallBus.mem_ready !== 1'b1 && cycles < INIT_BOUND) begin
            cycles++;
            @(negedge clk);
            if (cycles >= writeCycles) smallBus.Memory_writemode = 1'b0;
            #1;
        end
    endtask

    initial begin
        int cycles;
        int bigCycles;

        $display("[TB] bu2020_memory directed test starting");
        applyStimulus(12'h000, 16'h0000, 1'b0, 12'h000);
        bigBus.Memory_addressbus        = 12'h000;
        bigBus.Memory_incoming_data_bus = 16'h0000;
        bigBus.Memory_writemode         = 1'b0;
        bigBus.Instruction_addressbus   = 12'h000;

        // Reset and clear timing; a write during INIT to an already-cleared word is dropped.
        @(negedge clk);
        resetDut(2);
        applyStimulus(12'h000, 16'h1234, 1'b1, 12'h000);
        pushExpect("init_databus", 32'h0000);
        checkWord(smallBus.Memory_databus);
        pushExpect("init_instr_nop", 32'hD000);
        checkWord(smallBus.Instruction_databus);
        waitSmallReady(4, cycles);
        pushExpect("init_cycles", 32'd16);
        checkOutput(32'(cycles));
        applyStimulus(12'h000, 16'h0000, 1'b0, 12'h000);
        pushExpect("init_write_dropped", 32'h0000);
        checkWord(smallBus.Memory_databus);
        pushExpect("ready_addr_err", 32'd0);
        checkBit(smallBus.addr_err);

        // Full-size instance: wait for its clear, then write/read 0x123.
        bigCycles = 0;
        while (bigBus.mem_ready !== 1'b1 && bigCycles < BIG_BOUND) begin
            @(negedge clk);
            #1;
            bigCycles++;
        end
        pushExpect("big_ready", 32'd1);
        checkBit(bigBus.mem_ready);
        @(negedge clk);
        bigBus.Memory_addressbus        = 12'h123;
        bigBus.Memory_incoming_data_bus = 16'hBEEF;
        bigBus.Memory_writemode         = 1'b1;
        bigBus.Instruction_addressbus   = 12'h123;
        #1;
        pushExpect("big_same_cycle_data", 32'h0000);
        checkWord(bigBus.Memory_databus);
        pushExpect("big_same_cycle_instr", 32'h0000);
        checkWord(bigBus.Instruction_databus);
        pushExpect("big_next_data", 32'hBEEF);
        pushExpect("big_next_instr", 32'hBEEF);
        @(negedge clk);
        bigBus.Memory_writemode = 1'b0;
        #1;
        checkWord(bigBus.Memory_databus);
        checkWord(bigBus.Instruction_databus);

        // Small instance write/read with fetch of the same word.
        @(negedge clk);
        applyStimulus(12'h00C, 16'hBEEF, 1'b1, 12'h00C);
        pushExpect("wr_same_cycle_data", 32'h0000);
        checkWord(smallBus.Memory_databus);
        pushExpect("wr_next_data", 32'hBEEF);
        pushExpect("wr_next_instr", 32'hBEEF);
        @(negedge clk);
        applyStimulus(12'h00C, 16'h0000, 1'b0, 12'h00C);
        checkWord(smallBus.Memory_databus);
        checkWord(smallBus.Instruction_databus);

        // Overwrite while fetching the same word: fetch sees the old value.
        @(negedge clk);
        applyStimulus(12'h00C, 16'h5555, 1'b1, 12'h00C);
        pushExpect("ovw_fetch_old", 32'hBEEF);
        checkWord(smallBus.Instruction_databus);
        pushExpect("ovw_next_data", 32'h5555);
        @(negedge clk);
        applyStimulus(12'h00C, 16'h0000, 1'b0, 12'h00C);
        checkWord(smallBus.Memory_databus);

        // Out-of-range write to 20: ignored, reads 0, no aliasing onto word 4, sticky flag.
        @(negedge clk);
        applyStimulus(12'd20, 16'h1234, 1'b1, 12'h000);
        pushExpect("oor_same_cycle_flag", 32'd0);
        checkBit(smallBus.addr_err);
        @(negedge clk);
        applyStimulus(12'd20, 16'h0000, 1'b0, 12'h000);
        pushExpect("oor_read_zero", 32'h0000);
        checkWord(smallBus.Memory_databus);
        pushExpect("oor_addr_err_set", 32'd1);
        checkBit(smallBus.addr_err);
        @(negedge clk);
        applyStimulus(12'd4, 16'h0000, 1'b0, 12'd20);
        pushExpect("oor_no_alias", 32'h0000);
        checkWord(smallBus.Memory_databus);
        pushExpect("oor_fetch_nop", 32'hD000);
        checkWord(smallBus.Instruction_databus);
        pushExpect("oor_addr_err_sticky", 32'd1);
        checkBit(smallBus.addr_err);

        // Protection: word 2 is below the limit, word 4 is the first writable one.
        @(negedge clk);
        applyStimulus(12'd2, 16'hAAAA, 1'b1, 12'h000);
`ifdef BU2020_MEM_WRITE_PROTECT_EN
        pushExpect("prot_low_data", 32'h0000);
        pushExpect("prot_err_flag", 32'd1);
`else
        pushExpect("prot_low_data", 32'hAAAA);
        pushExpect("prot_err_flag", 32'd0);
`endif
        @(negedge clk);
        applyStimulus(12'd2, 16'h0000, 1'b0, 12'd2);
        checkWord(smallBus.Memory_databus);
        checkBit(smallBus.prot_err);
        @(negedge clk);
        applyStimulus(12'd4, 16'hAAAA, 1'b1, 12'h000);
        pushExpect("prot_limit_write", 32'hAAAA);
        @(negedge clk);
        applyStimulus(12'd4, 16'h0000, 1'b0, 12'h000);
        checkWord(smallBus.Memory_databus);

        // Fill the top word, then reset from READY and again mid-clear at count 9.
        @(negedge clk);
        applyStimulus(12'd15, 16'h7777, 1'b1, 12'h000);
        @(negedge clk);
        applyStimulus(12'd0, 16'h0000, 1'b0, 12'h000);
        resetDut(2);
        applyStimulus(12'd20, 16'h1234, 1'b1, 12'h000);
        repeat (9) @(negedge clk);
        #1;
        pushExpect("mid_init_not_ready", 32'd0);
        checkBit(smallBus.mem_ready);
        pushExpect("mid_init_nop", 32'hD000);
        checkWord(smallBus.Instruction_databus);
        resetDut(1);
        waitSmallReady(4, cycles);
        pushExpect("restart_cycles", 32'd16);
        checkOutput(32'(cycles));
        pushExpect("init_oor_no_flag", 32'd0);
        checkBit(smallBus.addr_err);
        applyStimulus(12'd0, 16'h0000, 1'b0, 12'h000);

        // Every word reads zero on both ports after the restarted clear.
        for (int i = 0; i < SMALL_DEPTH; i++) begin
            @(negedge clk);
            applyStimulus(12'(i), 16'h0000, 1'b0, 12'(SMALL_DEPTH - 1 - i));
            pushExpect("clear_data", 32'h0000);
            checkWord(smallBus.Memory_databus);
            pushExpect("clear_instr", 32'h0000);
            checkWord(smallBus.Instruction_databus);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/bu2020_memory.md
Name: bu2020_memory

Overview:
- Responder end of the BU2020 core's memory interfaces: one unified word-addressed RAM.
- Serves the read-only instruction port (fetch) and the read/write data port (MEM stage).
- Sits outside the core on the same clock, with its port names mirroring the core's bus names.
- After reset, a clear sequencer fills the whole array with zeros before the memory accepts accesses.

Parameters:
- DEPTH, 4096: number of 16-bit words. Must be ≤ 2^ADDR_W.
- ADDR_W, 12: address width of both ports.
- DATA_W, 16: word width.
- NOP_WORD, 16'hD000: instruction word returned while the memory is not ready.
- PROTECT_LIMIT, 256: first writable address when the write-protect feature is enabled.

Ports:
- clk, input, 1: system clock, rising-edge.
- rst, input, 1: synchronous, active-high reset.
- Memory_addressbus, input, ADDR_W: data-port word address.
- Memory_databus, output, DATA_W: data-port read data.
- Memory_incoming_data_bus, input, DATA_W: data-port write data.
- Memory_writemode, input, 1: 1 = write at the clock edge; 0 = read.
- Instruction_addressbus, input, ADDR_W: fetch address.
- Instruction_databus, output, DATA_W: fetched instruction.
- mem_ready, output, 1: high once the clear sequence has completed.
- addr_err, output, 1: sticky; an access was made at an address ≥ DEPTH.
- prot_err, output, 1: sticky; a write was blocked by protection. Constant 0 when the feature is compiled out.

Behaviour:
- FSM states are INIT and READY.
- Reset:
  - rst high at any edge puts the FSM in INIT, sets clr_cnt=0 and clears addr_err and prot_err. mem_ready becomes 0.
  - rst mid-INIT restarts the clear at address 0. rst in READY re-enters INIT, so contents are lost.
  - Reset values: mem_ready=0, addr_err=0, prot_err=0.
- INIT:
  - Each cycle writes mem[clr_cnt] <= 0 and then increments clr_cnt.
  - When clr_cnt==DEPTH-1 is written, the next state is READY. INIT therefore lasts exactly DEPTH cycles after rst deasserts.
  - mem_ready rises on the edge that completes word DEPTH-1.
  - Data port during INIT: writes are dropped silently and Memory_databus=0.
  - Instruction port during INIT: Instruction_databus=NOP_WORD.
- READY, reads:
  - Both ports read asynchronously with zero latency; each output is a combinational function of its address and the array.
  - Both ports may read the same address simultaneously.
- READY, writes:
  - When Memory_writemode=1 and the address is in range, mem[addr] <= Memory_incoming_data_bus at the rising edge.
  - In the write cycle, both read ports show the old contents; the new value is visible from the next cycle.
  - Same-address instruction and data accesses in one cycle are legal, and fetch sees the old word.
- Out-of-range addresses (≥ DEPTH):
  - A read returns 0, or NOP_WORD on the instruction port.
  - A write is ignored.
  - addr_err is set at the edge and stays set until rst. This applies in READY only; INIT accesses never set flags.
- Width rule: addresses are unsigned with no wrap; DEPTH==2^ADDR_W makes every address valid.

Optional Feature:
- Macro: BU2020_MEM_WRITE_PROTECT_EN.
- When defined, a data-port write in READY to an address < PROTECT_LIMIT is blocked: the array is unchanged and prot_err is set sticky at that edge. Reads are unaffected.
- When undefined, all in-range addresses are writable and prot_err is tied 0.

Decomposition:
- Package bu2020_mem_pkg holds:
  - ADDR_W=12, DATA_W=16 and NOP_WORD=16'hD000 constants.
  - A mem_state_t enum {INIT, READY}.
  - Typedefs addr_t and word_t, shared with the core.
- One sub-module, bu2020_mem_clear_seq, holds the INIT/READY FSM plus clr_cnt. It outputs clr_we, clr_addr and ready.
- The array, decode and flags stay in the top level.

Test Plan:
- Clear/ready timing: pulse rst for 2 cycles, DEPTH=16 → mem_ready=0 for exactly 16 cycles, then 1. During INIT, Instruction_databus=16'hD000 and Memory_databus=0.
- Write/read: in READY, write 16'hBEEF to addr 12'h123 → in the same cycle the read shows 0; from the next cycle Memory_databus=16'hBEEF and fetch at 12'h123 returns 16'hBEEF.
- Reset mid-INIT: with DEPTH=16, assert rst at clear count 9 → the clear restarts at 0 and mem_ready rises 16 cycles after release. Every word then reads 0, including words written before the reset.
- Out-of-range: with DEPTH=16, write 16'h1234 to address 20 → write ignored, read of addr 20 returns 0, addr_err=1 until rst. A write during INIT leaves addr_err=0 and the word reads 0 after ready.
- Protect (macro defined, PROTECT_LIMIT=4): write 16'hAAAA to addr 2 → addr 2 still reads 0 and prot_err=1. Write to addr 4 → succeeds and reads 16'hAAAA. With the macro undefined, addr 2 is written and prot_err stays 0.
